// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the two-master BRAM port arbiter.
package bram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  // Byte address width: word index + 2 byte bits + instr/data select bit
  function automatic int addr_w(input int size);
    return $clog2(size) + 3;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Per-master request/response bundle between the two BRAM masters and the arbiter.
interface bram_port_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 13,
  parameter int NUM_COL = 4
);
  logic               req0,      req1;
  logic               lock0,     lock1;
  logic [NUM_COL-1:0] we0,       we1;
  logic [ADDR_W-1:0]  addr0,     addr1;
  logic [WIDTH-1:0]   wdata0,    wdata1;
  logic               gnt0,      gnt1;
  logic               rvalid0,   rvalid1;
  logic [WIDTH-1:0]   rdata0,    rdata1;
  logic               lock_err0, lock_err1;

  modport master (
    output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, lock_err0, lock_err1
  );

  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, lock_err0, lock_err1
  );
endinterface

// File: rtl/bram_arb_rr.sv
// Two-way winner picker. BRAM_ARB_FIXED_PRIO_EN makes R0 win every contention;
// otherwise a tie goes to the master that was not granted last.
module bram_arb_rr
  import bram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_gnt,
  output req_id_t    winner,
  output logic       valid
);

`ifdef BRAM_ARB_FIXED_PRIO_EN
  logic unused_last_gnt_s;
  assign unused_last_gnt_s = last_gnt;

  // R0 always takes the port when it asks
  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req[0]) begin
      winner = 1'b0;
    end else begin
      winner = 1'b1;
    end
  end
`else
  // Sole requester wins; a tie alternates on last_gnt
  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_gnt;
      default: winner = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares the processor's single BRAM port between R0 (host bridge) and R1 (loader/debug).
// BRAM_ARB_FIXED_PRIO_EN: R0 always wins and breaks R1 locks at once; R0 locks never time out.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int SIZE     = 1024,
  parameter  int NUM_COL  = 4,
  parameter  int LOCK_MAX = 16,
  localparam int ADDR_W   = addr_w(SIZE),
  localparam int CNT_W    = $clog2(LOCK_MAX + 1)
) (
  input  logic               clk,
  input  logic               reset,
  bram_port_arbiter_if.slave bus,
  output logic [WIDTH-1:0]   bram_din,
  output logic [ADDR_W-1:0]  shared_bram_addr,
  output logic [NUM_COL-1:0] bram_wr_en,
  input  logic [WIDTH-1:0]   bram_dout
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(LOCK_MAX);

  arb_state_t       state_r, state_nxt_s;
  req_id_t          last_gnt_r, last_gnt_nxt_s, rr_winner_s, rtag_id_r;
  logic             rr_valid_s, rtag_valid_r, rd_beat_s;
  logic             timeout0_s, timeout1_s;
  logic             gnt0_s, gnt1_s, lock_err0_s, lock_err1_s;
  logic             rvalid0_s, rvalid1_s;
  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_nxt_s;

  bram_arb_rr u_rr (
    .req      ({bus.req1, bus.req0}),
    .last_gnt (last_gnt_r),
    .winner   (rr_winner_s),
    .valid    (rr_valid_s)
  );

  // Conditions under which the current owner's lock is revoked this cycle
  always_comb begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
    timeout0_s = 1'b0;
    timeout1_s = bus.req0;
`else
    timeout0_s = (hold_cnt_r == HOLD_MAX) && bus.req1;
    timeout1_s = (hold_cnt_r == HOLD_MAX) && bus.req0;
`endif
  end

  // Ownership FSM: next state, grants and lock-revocation pulses
  always_comb begin
    state_nxt_s    = state_r;
    last_gnt_nxt_s = last_gnt_r;
    hold_cnt_nxt_s = hold_cnt_r;
    gnt0_s         = 1'b0;
    gnt1_s         = 1'b0;
    lock_err0_s    = 1'b0;
    lock_err1_s    = 1'b0;
    if (!reset) begin
      state_nxt_s = ARB_IDLE;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          hold_cnt_nxt_s = {CNT_W{1'b0}};
          if (rr_valid_s) begin
            gnt0_s         = ~rr_winner_s;
            gnt1_s         = rr_winner_s;
            last_gnt_nxt_s = rr_winner_s;
            if (rr_winner_s ? bus.lock1 : bus.lock0) begin
              state_nxt_s = rr_winner_s ? ARB_OWN1 : ARB_OWN0;
            end else begin
              state_nxt_s = ARB_IDLE;
            end
          end else begin
            state_nxt_s = ARB_IDLE;
          end
        end
        ARB_OWN0: begin
          if (timeout0_s) begin
            lock_err0_s    = 1'b1;
            last_gnt_nxt_s = 1'b0;
            hold_cnt_nxt_s = {CNT_W{1'b0}};
            state_nxt_s    = ARB_IDLE;
          end else begin
            gnt0_s = bus.req0;
            if (bus.req1 && (hold_cnt_r < HOLD_MAX)) begin
              hold_cnt_nxt_s = hold_cnt_r + CNT_W'(1);
            end else begin
              hold_cnt_nxt_s = hold_cnt_r;
            end
            state_nxt_s = bus.lock0 ? ARB_OWN0 : ARB_IDLE;
          end
        end
        ARB_OWN1: begin
          if (timeout1_s) begin
            lock_err1_s    = 1'b1;
            last_gnt_nxt_s = 1'b1;
            hold_cnt_nxt_s = {CNT_W{1'b0}};
            state_nxt_s    = ARB_IDLE;
          end else begin
            gnt1_s = bus.req1;
            if (bus.req0 && (hold_cnt_r < HOLD_MAX)) begin
              hold_cnt_nxt_s = hold_cnt_r + CNT_W'(1);
            end else begin
              hold_cnt_nxt_s = hold_cnt_r;
            end
            state_nxt_s = bus.lock1 ? ARB_OWN1 : ARB_IDLE;
          end
        end
        default: state_nxt_s = ARB_IDLE;
      endcase
    end
  end

  // Drive the BRAM port from whichever master owns this beat; quiescent otherwise
  always_comb begin
    if (gnt0_s) begin
      shared_bram_addr = bus.addr0;
      bram_wr_en       = bus.we0;
      bram_din         = bus.wdata0;
    end else if (gnt1_s) begin
      shared_bram_addr = bus.addr1;
      bram_wr_en       = bus.we1;
      bram_din         = bus.wdata1;
    end else begin
      shared_bram_addr = {ADDR_W{1'b0}};
      bram_wr_en       = {NUM_COL{1'b0}};
      bram_din         = {WIDTH{1'b0}};
    end
  end

  assign rd_beat_s = (gnt0_s && (bus.we0 == {NUM_COL{1'b0}})) ||
                     (gnt1_s && (bus.we1 == {NUM_COL{1'b0}}));

  // State, pointer, hold counter and the read tag that routes bram_dout back
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ARB_IDLE;
      last_gnt_r   <= 1'b1;
      hold_cnt_r   <= {CNT_W{1'b0}};
      rtag_valid_r <= 1'b0;
      rtag_id_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      last_gnt_r   <= last_gnt_nxt_s;
      hold_cnt_r   <= hold_cnt_nxt_s;
      rtag_valid_r <= rd_beat_s;
      rtag_id_r    <= gnt1_s;
    end
  end

  // Gating with reset drops a response whose read was issued just before reset
  assign rvalid0_s     = rtag_valid_r && !rtag_id_r && reset;
  assign rvalid1_s     = rtag_valid_r &&  rtag_id_r && reset;
  assign bus.gnt0      = gnt0_s;
  assign bus.gnt1      = gnt1_s;
  assign bus.lock_err0 = lock_err0_s;
  assign bus.lock_err1 = lock_err1_s;
  assign bus.rvalid0   = rvalid0_s;
  assign bus.rvalid1   = rvalid1_s;
  assign bus.rdata0    = rvalid0_s ? bram_dout : {WIDTH{1'b0}};
  assign bus.rdata1    = rvalid1_s ? bram_dout : {WIDTH{1'b0}};

endmodule
